// File: rtl/dequant_stream.sv
// dequant_stream
//
// Streaming JPEG dequantiser. Each beat carries LANES signed coefficients of an
// 8x8 block in raster order. Every coefficient is multiplied by its quantisation
// step from one of two run-time-writable tables (bank 0 luma, bank 1 chroma).
// The product is saturated to OUT_W bits. Three register stages: lookup,
// product and saturated output. The whole pipe advances together, so a beat
// accepted at edge n is presented after edge n+2 and throughput is one beat per
// cycle.
//
// Ports
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_tbl_wr_*                  table write port (bank, element 8*row+col, step)
//   o_tbl_wr_err                one-cycle pulse: previous write hit a locked bank
//   i_in_valid / o_in_ready     input handshake
//   i_in_bank                   block bank, sampled on a block's first beat
//   i_in_data                   LANES coefficients, lane k at [k*COEF_W +: COEF_W]
//   o_out_valid / i_out_ready   output handshake
//   o_out_data                  LANES results, lane k at [k*OUT_W +: OUT_W]
//   o_out_last                  beat carrying elements 64-LANES..63
//   o_out_sat                   at least one lane of this beat was clamped
module dequant_stream #(
  parameter int unsigned COEF_W = 8,
  parameter int unsigned Q_W    = 8,
  parameter int unsigned OUT_W  = 11,
  parameter int unsigned LANES  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_tbl_wr_en,
  input  logic                     i_tbl_wr_bank,
  input  logic [5:0]               i_tbl_wr_addr,
  input  logic [Q_W-1:0]           i_tbl_wr_data,
  output logic                     o_tbl_wr_err,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic                     i_in_bank,
  input  logic [LANES*COEF_W-1:0]  i_in_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [LANES*OUT_W-1:0]   o_out_data,
  output logic                     o_out_last,
  output logic                     o_out_sat
);

  localparam int unsigned BEATS = 64 / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PW    = COEF_W + Q_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  localparam int unsigned LUMA [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99
  };

  localparam int unsigned CHROMA [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,
    18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,
    47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99
  };

  function automatic logic [Q_W-1:0] dflt_q(input int unsigned bank, input int unsigned elem);
    return (bank == 0) ? Q_W'(LUMA[elem]) : Q_W'(CHROMA[elem]);
  endfunction

  // Control
  logic w_advance;
  logic w_accept;
  logic w_first;
  logic w_bank;
  logic [1:0] w_lock;

  // Input side: beat counter, block bank, tables
  logic [CNT_W-1:0] r_cnt;
  logic             r_blk_bank;
  logic [Q_W-1:0]   r_tbl [2][64];
  logic             r_wr_err;
  logic [5:0]       w_elem [LANES];

  // Stage 1: coefficient plus looked-up step
  logic                     r_s1_valid;
  logic                     r_s1_last;
  logic                     r_s1_bank;
  logic signed [COEF_W-1:0] r_s1_coef [LANES];
  logic [Q_W-1:0]           r_s1_q [LANES];

  // Stage 2: full-precision product
  logic                 r_s2_valid;
  logic                 r_s2_last;
  logic                 r_s2_bank;
  logic signed [PW-1:0] r_s2_prod [LANES];
  logic signed [PW-1:0] w_prod [LANES];

  // Output stage
  logic                     r_out_valid;
  logic                     r_out_last;
  logic                     r_out_sat;
  logic                     r_out_bank;
  logic [LANES*OUT_W-1:0]   r_out_data;
  logic [LANES*OUT_W-1:0]   w_sat_data;
  logic [LANES-1:0]         w_sat_flag;

  assign w_advance  = !r_out_valid || i_out_ready;
  assign o_in_ready = w_advance && i_rst_n;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_first    = (r_cnt == '0);
  // The bank is taken live on beat 0 and from the latch for the rest of the block.
  assign w_bank     = w_first ? i_in_bank : r_blk_bank;

  // A bank is busy while any beat of a block using it sits anywhere in the pipe,
  // including a beat 0 being accepted this very cycle.
  always_comb begin
    w_lock = '0;
    if (!w_first)             w_lock[r_blk_bank] = 1'b1;
    if (w_accept && w_first)  w_lock[i_in_bank]  = 1'b1;
    if (r_s1_valid)           w_lock[r_s1_bank]  = 1'b1;
    if (r_s2_valid)           w_lock[r_s2_bank]  = 1'b1;
    if (r_out_valid)          w_lock[r_out_bank] = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_elem[k] = 6'(int'(r_cnt) * int'(LANES) + k);
      // Step is unsigned: widen with a zero sign bit before the signed multiply.
      w_prod[k] = PW'(r_s1_coef[k]) * PW'($signed({1'b0, r_s1_q[k]}));
    end
  end

  // Beat counter, block bank latch and quantisation tables
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_blk_bank <= 1'b0;
      r_wr_err   <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < 64; e++) begin
          r_tbl[b][e] <= dflt_q(b, e);
        end
      end
    end else begin
      r_wr_err <= i_tbl_wr_en && w_lock[i_tbl_wr_bank];
      if (i_tbl_wr_en && !w_lock[i_tbl_wr_bank]) begin
        r_tbl[i_tbl_wr_bank][i_tbl_wr_addr] <= i_tbl_wr_data;
      end
      if (w_accept) begin
        if (w_first) r_blk_bank <= i_in_bank;
        r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 1
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_bank  <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        r_s1_coef[k] <= '0;
        r_s1_q[k]    <= '0;
      end
    end else if (w_advance) begin
      r_s1_valid <= i_in_valid;
      r_s1_last  <= (r_cnt == LAST_CNT);
      r_s1_bank  <= w_bank;
      for (int k = 0; k < LANES; k++) begin
        r_s1_coef[k] <= i_in_data[k*COEF_W +: COEF_W];
        r_s1_q[k]    <= r_tbl[w_bank][w_elem[k]];
      end
    end
  end

  // Stage 2
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_bank  <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        r_s2_prod[k] <= '0;
      end
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_valid && r_s1_last;
      r_s2_bank  <= r_s1_bank;
      for (int k = 0; k < LANES; k++) begin
        r_s2_prod[k] <= w_prod[k];
      end
    end
  end

  // Per-lane saturation of the product to OUT_W bits
  for (genvar k = 0; k < LANES; k++) begin : g_sat
    if (OUT_W >= PW) begin : g_wide
      assign w_sat_data[k*OUT_W +: OUT_W] = OUT_W'(r_s2_prod[k]);
      assign w_sat_flag[k]                = 1'b0;
    end else begin : g_clamp
      logic [PW-OUT_W:0] w_top;
      logic              w_ovf;
      // Fits iff every bit from the OUT_W sign position upward equals the sign.
      assign w_top = r_s2_prod[k][PW-1:OUT_W-1];
      assign w_ovf = !((&w_top) || !(|w_top));
      assign w_sat_data[k*OUT_W +: OUT_W] =
          !w_ovf               ? r_s2_prod[k][OUT_W-1:0] :
          r_s2_prod[k][PW-1]   ? {1'b1, {(OUT_W-1){1'b0}}} :
                                 {1'b0, {(OUT_W-1){1'b1}}};
      assign w_sat_flag[k] = w_ovf;
    end
  end

  // Output stage; holds while stalled
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_sat   <= 1'b0;
      r_out_bank  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_advance) begin
      r_out_valid <= r_s2_valid;
      r_out_last  <= r_s2_valid && r_s2_last;
      r_out_sat   <= r_s2_valid && (|w_sat_flag);
      r_out_bank  <= r_s2_bank;
      r_out_data  <= w_sat_data;
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_out_last   = r_out_last;
  assign o_out_sat    = r_out_sat;
  assign o_tbl_wr_err = r_wr_err;

endmodule

// File: tb/tb_dequant_stream.sv
// Bench for dequant_stream: default instance (LANES=4, OUT_W=11) plus two sweep
// instances (LANES=1 and LANES=64, both OUT_W=16) sharing clock and reset.
module tb_dequant_stream;

  localparam int LUMA [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99
  };
  localparam int CHROMA [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,   18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,   47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99
  };

  logic clk, rst_n;
  logic tbl_wr_en, tbl_wr_bank, tbl_wr_err;
  logic [5:0] tbl_wr_addr;
  logic [7:0] tbl_wr_data;
  logic in_valid, in_ready, in_bank, out_valid, out_ready, out_last, out_sat;
  logic [31:0] in_data;
  logic [43:0] out_data;

  logic tie_en, tie_bank;
  logic [5:0] tie_addr;
  logic [7:0] tie_data;
  logic a_wr_err, a_in_valid, a_in_ready, a_in_bank, a_out_valid, a_out_ready, a_out_last, a_out_sat;
  logic [7:0] a_in_data;
  logic [15:0] a_out_data;
  logic b_wr_err, b_in_valid, b_in_ready, b_in_bank, b_out_valid, b_out_ready, b_out_last, b_out_sat;
  logic [511:0] b_in_data;
  logic [1023:0] b_out_data;

  int n_vec = 0;
  int n_err = 0;
  int m_tbl [2][64];

  dequant_stream #(.COEF_W(8), .Q_W(8), .OUT_W(11), .LANES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tbl_wr_en(tbl_wr_en), .i_tbl_wr_bank(tbl_wr_bank), .i_tbl_wr_addr(tbl_wr_addr),
    .i_tbl_wr_data(tbl_wr_data), .o_tbl_wr_err(tbl_wr_err),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_bank(in_bank), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_last(out_last), .o_out_sat(out_sat)
  );

  dequant_stream #(.COEF_W(8), .Q_W(8), .OUT_W(16), .LANES(1)) dut_l1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tbl_wr_en(tie_en), .i_tbl_wr_bank(tie_bank), .i_tbl_wr_addr(tie_addr),
    .i_tbl_wr_data(tie_data), .o_tbl_wr_err(a_wr_err),
    .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_bank(a_in_bank),
    .i_in_data(a_in_data), .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
    .o_out_data(a_out_data), .o_out_last(a_out_last), .o_out_sat(a_out_sat)
  );

  dequant_stream #(.COEF_W(8), .Q_W(8), .OUT_W(16), .LANES(64)) dut_l64 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tbl_wr_en(tie_en), .i_tbl_wr_bank(tie_bank), .i_tbl_wr_addr(tie_addr),
    .i_tbl_wr_data(tie_data), .o_tbl_wr_err(b_wr_err),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_bank(b_in_bank),
    .i_in_data(b_in_data), .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
    .o_out_data(b_out_data), .o_out_last(b_out_last), .o_out_sat(b_out_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int e = 0; e < 64; e++) begin
      m_tbl[0][e] = LUMA[e];
      m_tbl[1][e] = CHROMA[e];
    end
  endtask

  function automatic int satv(input int p, input int ow);
    int lim;
    lim = 1 << (ow - 1);
    if (p > lim - 1) return lim - 1;
    if (p < -lim) return -lim;
    return p;
  endfunction

  function automatic byte sweep_coef(input int e);
    return byte'((e * 37 + 5) & 255);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_sat !== 1'b0 || tbl_wr_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: got v=%b l=%b s=%b e=%b, want all 0",
               out_valid, out_last, out_sat, tbl_wr_err);
    end
    n_vec++;
    if (out_data !== 44'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h, want 0", out_data);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_ready_low: got %b, want 0", in_ready);
    end
    rst_n = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready_high: got %b, want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_luma_ones();
    logic [43:0] ev;
    int j;
    for (int i = 0; i < 20; i++) begin
      j = i - 3;
      if (j >= 0 && j < 16) begin
        ev = '0;
        for (int k = 0; k < 4; k++) ev[k*11 +: 11] = 11'(LUMA[j*4+k]);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== ev || out_sat !== 1'b0) begin
          n_err++;
          $display("FAIL luma_beat %0d: got v=%b d=%h s=%b, want v=1 d=%h s=0",
                   j, out_valid, out_data, out_sat, ev);
        end
        n_vec++;
        if (out_last !== (j == 15)) begin
          n_err++;
          $display("FAIL luma_last %0d: got %b, want %b", j, out_last, (j == 15));
        end
      end else begin
        n_vec++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL luma_idle cycle %0d: got out_valid %b, want 0", i, out_valid);
        end
      end
      in_valid  = (i < 16);
      in_bank   = 1'b0;
      in_data   = {4{8'd1}};
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    logic [43:0] ev;
    logic es;
    int j;
    for (int i = 0; i < 36; i++) begin
      j = i - 3;
      if (j >= 0 && j < 32) begin
        ev = '0;
        es = 1'b0;
        if (j == 0)  begin ev[10:0]  = 11'h400; es = 1'b1; end   // -128*17 -> -1024
        if (j == 15) begin ev[43:33] = 11'h3FF; es = 1'b1; end   // 127*99 -> 1023
        if (j == 16)       ev[10:0]  = 11'd80;                   // 5*16
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== ev || out_sat !== es
            || out_last !== (j == 15 || j == 31)) begin
          n_err++;
          $display("FAIL sat_beat %0d: got v=%b d=%h s=%b l=%b, want v=1 d=%h s=%b l=%b",
                   j, out_valid, out_data, out_sat, out_last, ev, es, (j == 15 || j == 31));
        end
      end
      in_valid  = (i < 32);
      in_bank   = (i < 16);
      in_data   = '0;
      if (i == 0)  in_data[7:0]   = 8'h80;
      if (i == 15) in_data[31:24] = 8'h7F;
      if (i == 16) in_data[7:0]   = 8'd5;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    byte coef [3][64];
    bit  banks [3];
    int src, snk, blk, b, e, p;
    logic [43:0] ev, prev_data;
    logic es, prev_stall, prev_last, prev_sat;
    banks[0] = 1'b0; banks[1] = 1'b1; banks[2] = 1'b0;
    for (int x = 0; x < 3; x++)
      for (int y = 0; y < 64; y++) coef[x][y] = byte'($urandom_range(0, 255));
    src = 0; snk = 0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0; prev_sat = 1'b0;
    for (int cyc = 0; cyc < 2000 && snk < 48; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (src < 48);
      blk = src / 16;
      if (blk > 2) blk = 2;
      in_bank = banks[blk];
      for (int k = 0; k < 4; k++) in_data[k*8 +: 8] = coef[blk][(src % 16) * 4 + k];
      #1;
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last
            || out_sat !== prev_sat) begin
          n_err++;
          $display("FAIL b2b_stall_hold: got v=%b d=%h, want v=1 d=%h", out_valid, out_data,
                   prev_data);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        blk = snk / 16;
        b = snk % 16;
        ev = '0;
        es = 1'b0;
        for (int k = 0; k < 4; k++) begin
          e = b * 4 + k;
          p = int'(coef[blk][e]) * m_tbl[banks[blk]][e];
          ev[k*11 +: 11] = 11'(satv(p, 11));
          if (satv(p, 11) != p) es = 1'b1;
        end
        n_vec++;
        if (out_data !== ev || out_sat !== es || out_last !== (b == 15)) begin
          n_err++;
          $display("FAIL b2b_beat %0d: got d=%h s=%b l=%b, want d=%h s=%b l=%b",
                   snk, out_data, out_sat, out_last, ev, es, (b == 15));
        end
        snk++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_data = out_data; prev_last = out_last; prev_sat = out_sat;
      if (in_valid && in_ready === 1'b1) src++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_vec++;
    if (snk != 48) begin
      n_err++;
      $display("FAIL b2b_count: got %0d beats, want 48", snk);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_table_load();
    int bank_of [4];
    int coef_of [4];
    logic [43:0] ev;
    int j, blk, b;
    bank_of = '{1, 0, 1, 0};
    coef_of = '{2, 1, 1, 1};
    tbl_wr_en = 1'b1; tbl_wr_bank = 1'b1; tbl_wr_addr = 6'd9; tbl_wr_data = 8'd3;
    @(posedge clk);
    #1;
    tbl_wr_en = 1'b0;
    m_tbl[1][9] = 3;
    n_vec++;
    if (tbl_wr_err !== 1'b0) begin
      n_err++;
      $display("FAIL tbl_idle_write_err: got %b, want 0", tbl_wr_err);
    end
    for (int i = 0; i < 67; i++) begin
      j = i - 3;
      if (j >= 0) begin
        blk = j / 16;
        b = j % 16;
        ev = '0;
        for (int k = 0; k < 4; k++)
          ev[k*11 +: 11] = 11'(coef_of[blk] * m_tbl[bank_of[blk]][b*4+k]);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== ev) begin
          n_err++;
          $display("FAIL tbl_beat %0d: got v=%b d=%h, want v=1 d=%h", j, out_valid, out_data, ev);
        end
        if (j == 2 || j == 32 || j == 33 || j == 48) begin
          n_vec++;
          if ((j == 2 && out_data[21:11] !== 11'd6) || (j == 32 && out_data[10:0] !== 11'd7)
              || (j == 33 && out_data[21:11] !== 11'd99)
              || (j == 48 && out_data[10:0] !== 11'd16)) begin
            n_err++;
            $display("FAIL tbl_point beat %0d: got %h, want 6/7/99/16 at the loaded element",
                     j, out_data);
          end
        end
      end
      if (i == 21 || i == 22 || i == 23 || i == 33) begin
        n_vec++;
        if (tbl_wr_err !== (i == 21 || i == 33)) begin
          n_err++;
          $display("FAIL tbl_wr_err cycle %0d: got %b, want %b", i, tbl_wr_err,
                   (i == 21 || i == 33));
        end
      end
      tbl_wr_en = (i == 20 || i == 22 || i == 32);
      tbl_wr_bank = (i != 20);
      tbl_wr_addr = (i == 32) ? 6'd5 : 6'd0;
      tbl_wr_data = (i == 20) ? 8'd50 : (i == 22) ? 8'd7 : 8'd200;
      if (i == 22) m_tbl[1][0] = 7;
      in_valid = (i < 64);
      in_bank = (bank_of[(i < 64) ? i / 16 : 3] != 0);
      in_data = {4{8'(coef_of[(i < 64) ? i / 16 : 3])}};
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    tbl_wr_en = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midblock();
    logic [43:0] ev;
    int j;
    tbl_wr_en = 1'b1; tbl_wr_bank = 1'b0; tbl_wr_addr = 6'd0; tbl_wr_data = 8'd33;
    @(posedge clk);
    #1;
    tbl_wr_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data[10:0] !== 11'd33) begin
          n_err++;
          $display("FAIL rst_pre_write: got v=%b lane0=%0d, want v=1 lane0=33",
                   out_valid, out_data[10:0]);
        end
      end
      in_valid = 1'b1; in_bank = 1'b0; in_data = {4{8'd1}}; out_ready = 1'b1;
      rst_n = (i != 8);
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 44'h0 || out_last !== 1'b0 || out_sat !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_flush: got v=%b d=%h, want v=0 d=0", out_valid, out_data);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      j = i - 3;
      if (j >= 0 && j < 16) begin
        ev = '0;
        for (int k = 0; k < 4; k++) ev[k*11 +: 11] = 11'(LUMA[j*4+k]);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== ev || out_last !== (j == 15)) begin
          n_err++;
          $display("FAIL rst_fresh_beat %0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   j, out_valid, out_data, out_last, ev, (j == 15));
        end
      end
      in_valid = (i < 16); in_bank = 1'b0; in_data = {4{8'd1}};
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_sweep();
    logic [15:0] ev;
    logic [1023:0] ev64;
    int j;
    for (int i = 0; i < 68; i++) begin
      j = i - 3;
      if (j >= 0 && j < 64) begin
        ev = 16'(int'(sweep_coef(j)) * CHROMA[j]);
        n_vec++;
        if (a_out_valid !== 1'b1 || a_out_data !== ev || a_out_sat !== 1'b0
            || a_out_last !== (j == 63)) begin
          n_err++;
          $display("FAIL l1_beat %0d: got v=%b d=%h s=%b l=%b, want v=1 d=%h s=0 l=%b",
                   j, a_out_valid, a_out_data, a_out_sat, a_out_last, ev, (j == 63));
        end
      end
      a_in_valid = (i < 64); a_in_bank = 1'b1; a_in_data = sweep_coef(i); a_out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    a_in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      j = i - 3;
      if (j >= 0) begin
        ev64 = '0;
        for (int k = 0; k < 64; k++)
          ev64[k*16 +: 16] = 16'(int'(sweep_coef(k + j)) * ((j == 1) ? CHROMA[k] : LUMA[k]));
        n_vec++;
        if (b_out_valid !== 1'b1 || b_out_data !== ev64 || b_out_sat !== 1'b0
            || b_out_last !== 1'b1) begin
          n_err++;
          $display("FAIL l64_beat %0d: got v=%b s=%b l=%b lane0=%h, want v=1 s=0 l=1 lane0=%h",
                   j, b_out_valid, b_out_sat, b_out_last, b_out_data[15:0], ev64[15:0]);
        end
      end
      b_in_valid = (i < 3); b_in_bank = (i == 1); b_out_ready = 1'b1;
      for (int k = 0; k < 64; k++) b_in_data[k*8 +: 8] = sweep_coef(k + i);
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    tbl_wr_en = 1'b0; tbl_wr_bank = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
    in_valid = 1'b0; in_bank = 1'b0; in_data = '0; out_ready = 1'b1;
    tie_en = 1'b0; tie_bank = 1'b0; tie_addr = '0; tie_data = '0;
    a_in_valid = 1'b0; a_in_bank = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_bank = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    model_reset();
    test_reset();
    test_luma_ones();
    test_saturation();
    test_back_to_back();
    test_table_load();
    test_reset_midblock();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dequant_stream.md
# dequant_stream

Streaming, parametrised JPEG dequantiser: multiplies signed DCT coefficients of 8x8 blocks by a quantisation step taken from one of two run-time-loadable tables (bank 0 luma, bank 1 chroma) and saturates each product to the output width. It processes LANES coefficients per beat under valid/ready flow control with full throughput. It sits between the entropy-decode/coefficient buffer and the IDCT, and replaces the single-shot, fixed-table, whole-block dequantiser.

## Interface
- COEF_W, 8, signed coefficient width
- Q_W, 8, unsigned quantisation-step width
- OUT_W, 11, signed output width (products saturated to this)
- LANES, 4, coefficients per beat; legal values 1,2,4,8,16,32,64
- Clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- tbl_wr_en  in  1  table write strobe
- tbl_wr_bank  in  1  table bank to write
- tbl_wr_addr  in  6  element index, 8*row+col
- tbl_wr_data  in  Q_W  quantisation step
- tbl_wr_err  out  1  one-cycle pulse: write dropped (bank locked)
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_bank  in  1  table bank for the block; sampled on a block's first beat only
- in_data  in  LANES*COEF_W  lane k = in_data[k*COEF_W +: COEF_W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  LANES*OUT_W  lane k = out_data[k*OUT_W +: OUT_W]
- out_last  out  1  last beat of a block
- out_sat  out  1  one or more lanes of this beat saturated

## Operation
- Block = 64 coefficients in raster order, BEATS = 64/LANES beats. Beat b, lane k carries element e = b*LANES+k.
- Input beat counter runs 0..BEATS-1 and wraps to 0 after the last beat. On beat 0, in_bank is latched as the block bank and held for all beats of that block.
- Stage 1 registers the coefficients plus q = table[bank][e] for each lane. Stage 2 computes the full-precision product coef*q, a signed value of COEF_W+Q_W bits with q zero-extended, then saturates it to OUT_W.
- Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat is the OR of the per-lane clamp flags. If OUT_W >= COEF_W+Q_W, no clamping occurs and out_sat is always 0.
- out_last = 1 on the output beat that carries elements 64-LANES..63.
- Tables are reset to the standard JPEG tables:
  - Bank 0 luma, row 0 = 16,11,10,16,24,40,51,61 … row 7 = 72,92,95,98,112,100,103,99.
  - Bank 1 chroma, row 0 = 17,18,24,47,99,99,99,99; row 1 = 18,21,26,66,99…; row 2 = 24,26,56,99…; row 3 = 47,66,99…; all other entries 99.
- Table lock: a bank is locked while any beat of a block that uses it is held in the counter, stage 1 or stage 2 (from the block's first accepted beat until its out_last beat is accepted).
  - A tbl_wr_en to a locked bank is dropped and tbl_wr_err pulses the next cycle.
  - A write to an unlocked bank takes effect the next cycle.
  - A write to bank X in the same cycle as a beat-0 acceptance selecting bank X is dropped, with tbl_wr_err.
- q = 0 is legal and yields a product of 0.

## Timing
- Pipeline advances when !out_valid || out_ready. in_ready equals that advance condition, gated low while reset is asserted.
- Latency: a beat accepted at edge n appears on out_data/out_valid after edge n+2, given no stalls.
- Throughput: 1 beat/cycle sustained, so one block every BEATS cycles, with no bubble between blocks.
- Backpressure: out_data, out_last and out_sat are held stable while out_valid && !out_ready. No beat is lost or duplicated.
- Reset, evaluated at a rising edge with reset = 0:
  - out_valid, out_last, out_sat and tbl_wr_err go to 0; out_data goes to 0.
  - Beat counter goes to 0 and the stage valids are cleared.
  - Tables reload their defaults and all locks clear.
  - Reset mid-block discards the partial block; the first beat after reset is treated as beat 0.
- in_ready is 1 in the first cycle after reset deasserts.

## Test plan
- Defaults, LANES=4, OUT_W=11: bank 0 block with all coefficients = 1 -> 16 beats; out_data equals the luma table (beat 0 lanes 16,11,10,16), out_last only on beat 15, first out_valid 2 cycles after the first accept.
- Saturation: element 0 coef = -128 with bank 1 (q = 17) -> -2176 clamps to -1024 with out_sat = 1; coef 127 at element 63 (q = 99) -> 12573 clamps to 1023; coef 5 at element 0 bank 0 -> 80, out_sat = 0.
- Back-to-back blocks with banks 0, 1, 0 and random out_ready (50%) -> outputs match the model, the bank switches exactly at block boundaries, and out_data is stable during stalls.
- Table load: write bank 1 element 9 = 3 while idle, then a block of coef 2 -> lane 1 of beat 2 = 6. Write bank 0 mid-block on bank 0 -> tbl_wr_err pulses and the value is unchanged; write bank 1 at the same time -> accepted.
- Reset asserted after beat 7 of a block -> out_valid = 0 next cycle, the table is restored to default, and a fresh block afterwards produces the correct 16 beats starting from element 0.
- Parameter sweep LANES = 1 and 64, OUT_W = 16 -> 64 beats / 1 beat per block, out_sat never set, results exact.
